vga_image_display: RTL and testbench

- Display-side consumer of the 256x256 framebuffer held in RAM port b.
- Generates 640x480@60 VGA timing and issues framebuffer read addresses.
- Captures the returned 32-bit pixel word and drives the 8-bit grayscale RGB, sync and blank pins of the DAC.
- Image is centred on screen; all other visible area shows the border colour.

---
 rtl/vga_image_display.sv | 167 ++++++++++++++++
 tb/tb_vga_image_display.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vga_image_display.sv
// Display-side framebuffer reader: 640x480@60 timing, centred grayscale image, border fill elsewhere.
// Latency: READ_LATENCY+1 cycles from counter value to every pin; pixel_addr/pixel_rd_en are combinational.
// Backpressure: none; free-running, pixel_data must be valid READ_LATENCY cycles after pixel_addr.
module vga_image_display #(
    parameter int         H_VISIBLE    = 640,
    parameter int         H_FP         = 16,
    parameter int         H_SYNC       = 96,
    parameter int         H_BP         = 48,
    parameter int         V_VISIBLE    = 480,
    parameter int         V_FP         = 10,
    parameter int         V_SYNC       = 2,
    parameter int         V_BP         = 33,
    parameter int         IMG_W        = 256,
    parameter int         IMG_H        = 256,
    parameter int         IMG_X0       = 192,
    parameter int         IMG_Y0       = 112,
    parameter int         READ_LATENCY = 1,
    parameter logic [7:0] BORDER       = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] pixel_addr,
    output logic        pixel_rd_en,
    input  logic [31:0] pixel_data,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int IMG_XB  = $clog2(IMG_W);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_VISIBLE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] IX_FIRST = HW'(IMG_X0);
    localparam logic [HW-1:0] IX_END   = HW'(IMG_X0 + IMG_W);
    localparam logic [HW-1:0] H_ONE    = HW'(1);

    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_VISIBLE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] IY_FIRST = VW'(IMG_Y0);
    localparam logic [VW-1:0] IY_END   = VW'(IMG_Y0 + IMG_H);
    localparam logic [VW-1:0] V_ONE    = VW'(1);

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + V_ONE;
        end else begin
            hcount <= hcount + H_ONE;
        end
    end

    logic          active;
    logic          hs;
    logic          vs;
    logic          in_img;
    logic          fs;
    logic [HW-1:0] img_col;
    logic [VW-1:0] img_row;
    logic [15:0]   addr_img;

    always_comb begin
        active   = (hcount < H_VIS) && (vcount < V_VIS);
        hs       = (hcount >= HS_FIRST) && (hcount <= HS_LAST);
        vs       = (vcount >= VS_FIRST) && (vcount <= VS_LAST);
        in_img   = (hcount >= IX_FIRST) && (hcount < IX_END) &&
                   (vcount >= IY_FIRST) && (vcount < IY_END);
        fs       = (hcount == '0) && (vcount == '0);
        img_col  = hcount - IX_FIRST;
        img_row  = vcount - IY_FIRST;
        addr_img = (16'(img_row) << IMG_XB) | 16'(img_col);
    end

    // Fetch is suppressed while reset is held so the RAM never sees a stray read.
    assign pixel_rd_en = in_img & ~reset;
    assign pixel_addr  = pixel_rd_en ? addr_img : 16'h0000;

    logic [READ_LATENCY:1] act_d;
    logic [READ_LATENCY:1] hs_d;
    logic [READ_LATENCY:1] vs_d;
    logic [READ_LATENCY:1] img_d;
    logic [READ_LATENCY:1] fs_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            act_d <= '0;
            hs_d  <= '0;
            vs_d  <= '0;
            img_d <= '0;
            fs_d  <= '0;
        end else begin
            act_d[1] <= active;
            hs_d[1]  <= hs;
            vs_d[1]  <= vs;
            img_d[1] <= in_img;
            fs_d[1]  <= fs;
            for (int i = 2; i <= READ_LATENCY; i++) begin
                act_d[i] <= act_d[i-1];
                hs_d[i]  <= hs_d[i-1];
                vs_d[i]  <= vs_d[i-1];
                img_d[i] <= img_d[i-1];
                fs_d[i]  <= fs_d[i-1];
            end
        end
    end

    logic [7:0] pix_q;
    logic       hsync_q;
    logic       vsync_q;
    logic       blank_n_q;
    logic       fs_q;

    // RAM data is only trusted when the matching delayed in_img flag is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q     <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_n_q <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            hsync_q   <= ~hs_d[READ_LATENCY];
            vsync_q   <= ~vs_d[READ_LATENCY];
            blank_n_q <= act_d[READ_LATENCY];
            fs_q      <= fs_d[READ_LATENCY];
            if (!act_d[READ_LATENCY]) begin
                pix_q <= '0;
            end else if (img_d[READ_LATENCY]) begin
                pix_q <= pixel_data[7:0];
            end else begin
                pix_q <= BORDER;
            end
        end
    end

    logic data_unused;
    assign data_unused = ^pixel_data[31:8];

    assign vga_r       = pix_q;
    assign vga_g       = pix_q;
    assign vga_b       = pix_q;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_image_display.sv
// Bench for vga_image_display: full-width lines, shortened vertical geometry so whole frames stay short.
module tb_vga_image_display;

    localparam int         L      = 2;
    localparam int         H_TOT  = 800;
    localparam int         V_TOT  = 30;
    localparam int         FRAME  = H_TOT * V_TOT;
    localparam logic [7:0] BRD    = 8'h3C;
    localparam int         N_RUN  = FRAME + 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pixel_addr;
    logic        pixel_rd_en;
    logic [31:0] pixel_data;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, frame_start;

    always #5 clk = ~clk;

    vga_image_display #(
        .V_VISIBLE(24), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .IMG_Y0(4), .IMG_H(16), .READ_LATENCY(1), .BORDER(BRD)
    ) dut (
        .clk(clk), .reset(reset),
        .pixel_addr(pixel_addr), .pixel_rd_en(pixel_rd_en), .pixel_data(pixel_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
        .frame_start(frame_start)
    );

    // One-cycle RAM; non-image reads return garbage that must never reach the pins.
    always @(posedge clk) begin
        pixel_data <= pixel_rd_en ? {24'hABCDEF, pixel_addr[7:0] ^ pixel_addr[15:8]}
                                  : 32'hDEADBEEF;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    int cyc;
    int hs_low0 = 0, hs_low1 = 0, hs_first0 = -1, hs_first1 = -1;
    int blank_hi0 = 0, blank_first0 = -1, blank_hi_frame = 0;
    int vs_low = 0, vs_first = -1;
    int rd_cnt = 0, addr_bad = 0, idle_bad = 0;
    int fs_cnt = 0, fs_first = -1, fs_second = -1;
    int pix_bad = 0, chan_bad = 0;

    initial begin
        int c, h, v, e;
        bit act, img;
        logic [7:0] exp_pix;

        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_pins", {vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, frame_start, pixel_rd_en},
                6'b110000);
            chk("rst_rgb", {vga_r, vga_g, vga_b}, 24'h0);
            chk("rst_addr", pixel_addr, 16'h0);
        end
        reset = 1'b0;

        cyc = 0;
        while (cyc < N_RUN) begin
            if (cyc < FRAME) begin
                if (pixel_rd_en) begin
                    if (pixel_addr != rd_cnt[15:0]) addr_bad++;
                    rd_cnt++;
                end else if (pixel_addr != 16'h0) begin
                    idle_bad++;
                end
                if (!vga_vsync) begin
                    if (vs_first < 0) vs_first = cyc;
                    vs_low++;
                end
                if (vga_blank_n) blank_hi_frame++;
                c = cyc - L;
                if (c >= 0) begin
                    h = c % H_TOT;
                    v = (c / H_TOT) % V_TOT;
                    act = (h < 640) && (v < 24);
                    img = (h >= 192) && (h < 448) && (v >= 4) && (v < 20);
                    e = (v - 4) ^ (h - 192);
                    exp_pix = !act ? 8'h00 : (img ? 8'(e) : BRD);
                    if (vga_r !== exp_pix || vga_blank_n !== act) pix_bad++;
                end
            end
            if (cyc < H_TOT) begin
                if (!vga_hsync) begin
                    if (hs_first0 < 0) hs_first0 = cyc;
                    hs_low0++;
                end
                if (vga_blank_n) begin
                    if (blank_first0 < 0) blank_first0 = cyc;
                    blank_hi0++;
                end
            end else if (cyc < 2 * H_TOT) begin
                if (!vga_hsync) begin
                    if (hs_first1 < 0) hs_first1 = cyc;
                    hs_low1++;
                end
            end
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_cnt == 1) fs_first = cyc;
                else if (fs_cnt == 2) fs_second = cyc;
            end
            if (vga_r !== vga_g || vga_r !== vga_b) chan_bad++;

            case (cyc)
                3392:  chk("addr_first_img", {pixel_rd_en, pixel_addr}, {1'b1, 16'h0000});
                3393:  chk("col191_border", {vga_blank_n, vga_r}, {1'b1, BRD});
                3394:  chk("px_r0c0", {vga_blank_n, vga_r}, {1'b1, 8'h00});
                3650:  chk("col448_border", {vga_blank_n, vga_r}, {1'b1, BRD});
                3842:  chk("col640_blank", {vga_blank_n, vga_r}, 9'h000);
                4197:  chk("px_r1c3", vga_r, 8'h02);
                15649: chk("px_r15c255", vga_r, 8'hF0);
                default: ;
            endcase

            @(negedge clk);
            cyc++;
        end

        chk("fs_count", fs_cnt, 2);
        chk("fs_first", fs_first, 2);
        chk("fs_period", fs_second - fs_first, FRAME);
        chk("hs_low_line0", hs_low0, 96);
        chk("hs_first_line0", hs_first0, 658);
        chk("hs_low_line1", hs_low1, 96);
        chk("hs_first_line1", hs_first1, 1458);
        chk("blank_hi_line0", blank_hi0, 640);
        chk("blank_first", blank_first0, 2);
        chk("blank_hi_frame", blank_hi_frame, 640 * 24);
        chk("vs_low", vs_low, 1600);
        chk("vs_first", vs_first, 26 * H_TOT + L);
        chk("rd_count", rd_cnt, 4096);
        chk("addr_seq", addr_bad, 0);
        chk("addr_idle", idle_bad, 0);
        chk("pix_frame", pix_bad, 0);
        chk("rgb_equal", chan_bad, 0);

        // Mid-frame reset while counters sit at line 10, column 400.
        while ((cyc % FRAME) != (10 * H_TOT + 400)) begin
            @(negedge clk);
            cyc++;
        end
        chk("pre_rst_px", {vga_blank_n, vga_r}, {1'b1, 8'hC8});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_m0_pins", {vga_hsync, vga_vsync, vga_blank_n, frame_start}, 4'b1100);
        chk("mid_rst_m0_rgb", vga_r, 8'h00);
        chk("mid_rst_m0_rd", {pixel_rd_en, pixel_addr}, 17'h0);
        @(negedge clk);
        chk("mid_rst_m1_pins", {vga_hsync, vga_vsync, vga_blank_n, frame_start}, 4'b1100);
        chk("mid_rst_m1_rgb", vga_r, 8'h00);
        @(negedge clk);
        chk("mid_rst_m2_pins", {vga_hsync, vga_vsync, vga_blank_n, frame_start}, 4'b1111);
        chk("mid_rst_m2_rgb", vga_r, BRD);
        @(negedge clk);
        chk("mid_rst_m3_fs", frame_start, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
